// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle for fifo_wr_arbiter.
// master drives requests, data and FIFO status; slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [3:0]            REQ;
  logic [DATA_WIDTH-1:0] DATA0;
  logic [DATA_WIDTH-1:0] DATA1;
  logic [DATA_WIDTH-1:0] DATA2;
  logic [DATA_WIDTH-1:0] DATA3;
  logic                  FIFO_FULL;
  logic [3:0]            GNT;
  logic                  FIFO_WR_EN;
  logic [DATA_WIDTH-1:0] FIFO_DATA_IN;
  logic                  STALL;
  logic [15:0]           ACCEPT_CNT;

  modport master (
    output REQ, DATA0, DATA1, DATA2, DATA3, FIFO_FULL,
    input  GNT, FIFO_WR_EN, FIFO_DATA_IN, STALL, ACCEPT_CNT
  );

  modport slave (
    input  REQ, DATA0, DATA1, DATA2, DATA3, FIFO_FULL,
    output GNT, FIFO_WR_EN, FIFO_DATA_IN, STALL, ACCEPT_CNT
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Four-requester write arbiter in front of a synchronous FIFO: round-robin
// with bounded bursts, zero-cycle grant, stall while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic             FCLK,
  input  logic             FRSTN,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [3:0] BLIM = 4'(BURST_MAX - 1);

  state_t                state;
  logic [1:0]            own;
  logic [3:0]            bcnt;
  logic [15:0]           accept_q;

  logic                  any_req;
  logic                  go;
  logic                  keep;
  logic                  found;
  logic [1:0]            winner;
  logic [1:0]            idx;
  logic [3:0]            gnt;
  logic [DATA_WIDTH-1:0] wdata;

  always_comb begin
    any_req = |bus.REQ;
    go      = any_req && !bus.FIFO_FULL && FRSTN;
    keep    = (state == LOCKED) && bus.REQ[own] && (bcnt < BLIM);
    winner  = own;
    found   = 1'b0;
    idx     = own;
    if (!keep) begin
      // scan ends on the current owner, so it has lowest priority
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = own + 2'(k);
        if (!found && bus.REQ[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
    gnt   = '0;
    wdata = '0;
    if (go) begin
      gnt[winner] = 1'b1;
      case (winner)
        2'd0:    wdata = bus.DATA0;
        2'd1:    wdata = bus.DATA1;
        2'd2:    wdata = bus.DATA2;
        default: wdata = bus.DATA3;
      endcase
    end
  end

  assign bus.GNT          = gnt;
  assign bus.FIFO_WR_EN   = go;
  assign bus.FIFO_DATA_IN = wdata;
  assign bus.STALL        = any_req && bus.FIFO_FULL && FRSTN;
  assign bus.ACCEPT_CNT   = accept_q;

  always_ff @(posedge FCLK or negedge FRSTN) begin
    if (!FRSTN) begin
      state    <= IDLE;
      own      <= 2'd3;
      bcnt     <= '0;
      accept_q <= '0;
    end else if (!any_req) begin
      state <= IDLE;
      bcnt  <= '0;
    end else if (go) begin
      accept_q <= accept_q + 16'd1;
      if (state == LOCKED && winner == own) begin
        // saturate so a long solo run cannot wrap back into a fresh burst
        if (bcnt != 4'hF) bcnt <= bcnt + 4'd1;
      end else begin
        own   <= winner;
        bcnt  <= '0;
        state <= LOCKED;
      end
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester data bus and of the FIFO write data bus.
REQ-002 Parameter BURST_MAX, default 4: maximum consecutive grants to one requester before rotation; legal range 1..16.
REQ-003 FCLK  input  1: clock; all state updates on rising edge.
REQ-004 FRSTN  input  1: reset, asynchronous, active-low.
REQ-005 REQ  input  4: per-requester write request; REQ[i] held with DATA_i stable until GNT[i] sampled high.
REQ-006 DATA0, DATA1, DATA2, DATA3  input  DATA_WIDTH each: write data of requester 0..3.
REQ-007 FIFO_FULL  input  1: FULL status of the downstream synchronous FIFO.
REQ-008 GNT  output  4: one-hot grant; GNT[i] high means DATA_i is written at this rising edge.
REQ-009 FIFO_WR_EN  output  1: write enable to the downstream FIFO.
REQ-010 FIFO_DATA_IN  output  DATA_WIDTH: write data to the downstream FIFO.
REQ-011 STALL  output  1: high when any REQ bit is high and FIFO_FULL is high.
REQ-012 ACCEPT_CNT  output  16: count of accepted writes, wraps 16'hFFFF -> 16'h0000.

Function
REQ-013 Internal state: OWN (2-bit last/current owner), BCNT (4-bit burst count), FSM state IDLE or LOCKED.
REQ-014 GO = (REQ != 4'b0000) && !FIFO_FULL; GNT, FIFO_WR_EN, FIFO_DATA_IN combinational from registered state and current inputs (zero-cycle grant latency).
REQ-015 Winner: if LOCKED, REQ[OWN]=1 and BCNT < BURST_MAX-1 -> OWN; else first set REQ bit scanning OWN+1, OWN+2, OWN+3, OWN (mod 4).
REQ-016 When GO=1: GNT = one-hot of winner, FIFO_WR_EN=1, FIFO_DATA_IN = winner's DATA; otherwise GNT=4'b0000, FIFO_WR_EN=0, FIFO_DATA_IN=all zeros.
REQ-017 At most one GNT bit high in any cycle; FIFO_WR_EN equals OR of GNT.
REQ-018 Edge with GO=1, LOCKED, winner==OWN: BCNT <= BCNT+1, state stays LOCKED.
REQ-019 Edge with GO=1, otherwise: OWN <= winner, BCNT <= 0, state <= LOCKED.
REQ-020 Edge with REQ=4'b0000: state <= IDLE, BCNT <= 0, OWN holds (previous owner lowest priority next time).
REQ-021 Edge with REQ!=0 and FIFO_FULL=1: OWN, BCNT, state, ACCEPT_CNT all hold; burst resumes unchanged when FULL clears.
REQ-022 Owner dropping REQ mid-burst: rotation to next requester occurs the same cycle, no idle bubble.
REQ-023 BURST_MAX=1: pure round-robin, every grant rotates.
REQ-024 ACCEPT_CNT increments by 1 on every edge with FIFO_WR_EN=1.
REQ-025 FIFO_FULL sampled only combinationally; no write issued while FIFO_FULL=1 (no overflow possible).

Reset
REQ-026 FRSTN low asynchronously forces OWN=2'd3, BCNT=0, state=IDLE, ACCEPT_CNT=0 (requester 0 has first priority after reset).
REQ-027 While FRSTN low, GNT=4'b0000, FIFO_WR_EN=0, FIFO_DATA_IN=0, STALL=0 regardless of inputs.
REQ-028 Reset mid-burst discards burst state; first grant after release follows REQ-015 from reset values.

Verification
REQ-029 BURST_MAX=2, REQ=4'b1111 held, FULL=0, DATAi=8'hA0+i -> GNT sequence 0,0,1,1,2,2,3,3,0; FIFO_DATA_IN A0,A0,A1,A1,A2,A2,A3,A3,A0.
REQ-030 BURST_MAX=4, REQ=4'b0011, requester 0 drops REQ after 2 grants -> next cycle GNT=4'b0010, no idle cycle, BCNT restarts at 0.
REQ-031 REQ=4'b0101, FULL=1 for 3 cycles mid-burst -> GNT=0, STALL=1, ACCEPT_CNT frozen; after FULL=0 same owner continues remaining burst.
REQ-032 ACCEPT_CNT preloaded to 16'hFFFE via 2 accepted writes after forcing -> wraps to 16'h0000; after reset from 16'h0005 -> 16'h0000 immediately.
REQ-033 FRSTN pulsed low during owner-2 burst -> outputs zero asynchronously; after release with REQ=4'b1111 first GNT=4'b0001.
REQ-034 Random REQ/FULL for 10000 cycles -> GNT one-hot-or-zero, no grant while FULL=1, every held request granted within 4*BURST_MAX accepting cycles.
